// File: rtl/pool_frame_scheduler.sv
// Frame scheduler sharing one mean-pooling engine between NCH channel buffers.
// Define POOL_SCHED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module pool_frame_scheduler #(
  parameter int NCH  = 4,
  parameter int WD   = 1,
  parameter int COLS = 28,
  parameter int ROWS = 28,
  parameter int HGAP = 4,
  parameter int TAIL = 4
) (
  input  logic              i_sclk,
  input  logic              i_rstn,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH*WD-1:0] i_tdata,
  output logic [NCH-1:0]    o_rd,
  output logic [NCH-1:0]    o_gnt,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_valid,
  output logic [WD-1:0]     o_tdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_done_ch
);

  localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW   = $clog2(COLS + 1);
  localparam int GMAX = (HGAP > TAIL) ? HGAP : TAIL;
  localparam int GW   = $clog2(GMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_VS, S_HS, S_ROW, S_GAP, S_TAIL, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [7:0]     row_q, row_d;
  logic [GW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [2:0]     gidx_q, gidx_d;
  logic [NCH-1:0] gnt_q, gnt_d, rd_q, rd_d;
  logic           vsync_q, vsync_d, hsync_q, hsync_d, valid_q, valid_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [WD-1:0]  tdata_q, tdata_d, sel;
  logic [2:0]     done_ch_q, done_ch_d;
  logic           win_found;
  logic [2:0]     win_idx;

  // Arbiter: first requester found scanning upward from the search start.
  always_comb begin
    int k;
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int i = 0; i < NCH; i++) begin
`ifdef POOL_SCHED_PRIO_EN
      k = i;
`else
      k = int'(ptr_q) + i;
      if (k >= NCH) k = k - NCH;
`endif
      if (!win_found && i_req[k[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = 3'(k);
      end
    end
  end

  // Granted channel's slice, via the one-hot grant (bit-transposed OR).
  logic [WD-1:0][NCH-1:0] tr;
  for (genvar b = 0; b < WD; b++) begin : g_bit
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign tr[b][g] = i_tdata[g*WD+b] & gnt_q[g];
    end
    assign sel[b] = |tr[b];
  end

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gidx_q    <= '0;
      gnt_q     <= '0;
      rd_q      <= '0;
      vsync_q   <= 1'b0;
      hsync_q   <= 1'b0;
      valid_q   <= 1'b0;
      tdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      gnt_q     <= gnt_d;
      rd_q      <= rd_d;
      vsync_q   <= vsync_d;
      hsync_q   <= hsync_d;
      valid_q   <= valid_d;
      tdata_q   <= tdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    case (state_q)
      S_IDLE: if (win_found) begin
        state_d = S_VS;
        gidx_d  = win_idx;
        gnt_d   = NCH'(1) << win_idx;
`ifdef POOL_SCHED_PRIO_EN
        ptr_d   = '0;
`else
        ptr_d   = (int'(win_idx) == NCH - 1) ? '0 : PW'(win_idx + 3'd1);
`endif
      end
      S_VS: begin
        row_d   = '0;
        col_d   = '0;
        state_d = S_HS;
      end
      S_HS: begin
        col_d   = '0;
        state_d = S_ROW;
      end
      S_ROW: if (col_q == CW'(COLS - 1)) begin
        col_d   = '0;
        row_d   = row_q + 8'd1;
        cnt_d   = '0;
        state_d = S_GAP;
      end else begin
        col_d   = col_q + CW'(1);
      end
      S_GAP: if (cnt_q == GW'(HGAP - 1)) begin
        cnt_d   = '0;
        if (row_q < 8'(ROWS)) state_d = S_HS;
        else                  state_d = (TAIL == 0) ? S_DONE : S_TAIL;
      end else begin
        cnt_d   = cnt_q + GW'(1);
      end
      S_TAIL: if (cnt_q == GW'(TAIL - 1)) begin
        cnt_d   = '0;
        state_d = S_DONE;
      end else begin
        cnt_d   = cnt_q + GW'(1);
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the next state so each pulse lines up with its state cycle.
  always_comb begin
    vsync_d   = (state_d == S_VS);
    hsync_d   = (state_d == S_HS);
    rd_d      = (state_d == S_ROW) ? gnt_d : '0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    done_ch_d = done_d ? gidx_d : '0;
    valid_d   = |rd_q;
    tdata_d   = (|rd_q) ? sel : '0;
  end

  assign o_rd      = rd_q;
  assign o_gnt     = gnt_q;
  assign o_vsync   = vsync_q;
  assign o_hsync   = hsync_q;
  assign o_valid   = valid_q;
  assign o_tdata   = tdata_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_done_ch = done_ch_q;

endmodule

// File: tb/tb_pool_frame_scheduler.sv
// Directed bench for pool_frame_scheduler: NCH=4, COLS=4, ROWS=4, HGAP=2, TAIL=4.
module tb_pool_frame_scheduler;
  localparam int NCH = 4, WD = 1, COLS = 4, ROWS = 4, HGAP = 2, TAIL = 4;
  localparam int FLEN = 1 + ROWS * (1 + COLS + HGAP) + TAIL + 1;

  logic clk = 1'b0, rstn = 1'b1;
  logic [NCH-1:0] req = '0;
  logic [NCH*WD-1:0] tdata = '0;
  logic [NCH-1:0] o_rd, o_gnt;
  logic o_vsync, o_hsync, o_valid, o_busy, o_done;
  logic [WD-1:0] o_tdata;
  logic [2:0] o_done_ch;
  int n_cmp = 0, n_bad = 0;

  pool_frame_scheduler #(.NCH(NCH), .WD(WD), .COLS(COLS), .ROWS(ROWS), .HGAP(HGAP), .TAIL(TAIL)) dut (
    .i_sclk(clk), .i_rstn(rstn), .i_req(req), .i_tdata(tdata), .o_rd(o_rd), .o_gnt(o_gnt),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_valid(o_valid), .o_tdata(o_tdata),
    .o_busy(o_busy), .o_done(o_done), .o_done_ch(o_done_ch));

  always #5 clk = ~clk;

  // Observes one frame from the current negedge; returns on the negedge after DONE.
  task automatic watch_frame(output bit ok, output logic [3:0] gnt, output int wait_n, output int len,
                             output int nvs, output int nhs, output int runs, output int bad,
                             output logic [2:0] dch, output bit vs_first, output logic busy_after);
    int run;
    bit prev_hs;
    ok = 0; gnt = '0; wait_n = 0; len = 0; nvs = 0; nhs = 0; runs = 0; bad = 0;
    dch = '0; vs_first = 0; busy_after = 1'b1; run = 0; prev_hs = 0;
    while (o_busy !== 1'b1 && wait_n < 40) begin @(negedge clk); wait_n++; end
    if (o_busy !== 1'b1) return;
    gnt = o_gnt; vs_first = o_vsync;
    for (int i = 0; i < 60; i++) begin
      len++;
      if (o_vsync) nvs++;
      if (o_hsync) nhs++;
      if (o_gnt !== gnt) bad++;
      if (o_rd != '0) begin
        if (o_rd === gnt) run++; else bad++;
      end else if (run != 0) begin
        if (run == COLS) runs++; else bad++;
        run = 0;
      end
      if (prev_hs && o_rd !== gnt) bad++;
      prev_hs = o_hsync;
      if (o_done) begin ok = 1; dch = o_done_ch; break; end
      @(negedge clk);
    end
    @(negedge clk);
    busy_after = o_busy | (|o_gnt);
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #1;
    n_cmp++; if (o_gnt !== 4'b0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", o_gnt); end
    n_cmp++; if (o_rd !== 4'b0) begin n_bad++; $display("FAIL reset_rd: got %b want 0000", o_rd); end
    n_cmp++; if ({o_vsync, o_hsync, o_valid, o_busy, o_done} !== 5'b0)
      begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {o_vsync, o_hsync, o_valid, o_busy, o_done}); end
    n_cmp++; if ({o_tdata, o_done_ch} !== 4'b0) begin n_bad++; $display("FAIL reset_data: got %b want 0000", {o_tdata, o_done_ch}); end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_single();
    bit ok, vsf; logic [3:0] g; int w, len, nvs, nhs, runs, bad; logic [2:0] dch; logic ba;
    req = 4'b0001;
    watch_frame(ok, g, w, len, nvs, nhs, runs, bad, dch, vsf, ba);
    req = 4'b0000;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_done_seen: got %0d want 1", ok); end
    n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL single_gnt: got %b want 0001", g); end
    n_cmp++; if (w != 1) begin n_bad++; $display("FAIL single_latency: got %0d want 1", w); end
    n_cmp++; if (len != FLEN) begin n_bad++; $display("FAIL single_len: got %0d want %0d", len, FLEN); end
    n_cmp++; if (nvs != 1 || vsf !== 1'b1) begin n_bad++; $display("FAIL single_vsync: got %0d first %0d want 1 1", nvs, vsf); end
    n_cmp++; if (nhs != ROWS) begin n_bad++; $display("FAIL single_hsync: got %0d want %0d", nhs, ROWS); end
    n_cmp++; if (runs != ROWS) begin n_bad++; $display("FAIL single_rd_runs: got %0d want %0d", runs, ROWS); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_struct: got %0d errors want 0", bad); end
    n_cmp++; if (dch !== 3'd0) begin n_bad++; $display("FAIL single_done_ch: got %0d want 0", dch); end
    n_cmp++; if (ba !== 1'b0) begin n_bad++; $display("FAIL single_release: got %b want 0", ba); end
  endtask

  task automatic test_datapath();
    bit seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic exp_q [$];
    logic b, expv, prev_rd;
    bit done;
    int cidx, nval, lag_bad, zero_bad;
    logic [2:0] dch;
    prev_rd = 1'b0; done = 0; cidx = 0; nval = 0; lag_bad = 0; zero_bad = 0; dch = '0;
    req = 4'b0100;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (o_valid !== prev_rd) lag_bad++;
      if (o_valid === 1'b1) begin
        nval++;
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL dp_data: got %b want nothing (no read)", o_tdata); end
        else begin
          expv = exp_q.pop_front();
          if (o_tdata !== expv) begin n_bad++; $display("FAIL dp_data: sample %0d got %b want %b", nval, o_tdata, expv); end
        end
      end else if (o_tdata !== 1'b0) zero_bad++;
      prev_rd = |o_rd;
      if (o_rd[2] === 1'b1) begin
        b = seq[cidx % 4]; cidx++;
        exp_q.push_back(b);
        tdata = {~b, b, ~b, ~b};
      end else tdata = 4'b1111;
      if (o_done === 1'b1) begin done = 1; dch = o_done_ch; break; end
    end
    req = 4'b0000; tdata = '0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL dp_done_seen: got %0d want 1", done); end
    n_cmp++; if (dch !== 3'd2) begin n_bad++; $display("FAIL dp_done_ch: got %0d want 2", dch); end
    n_cmp++; if (nval != ROWS * COLS) begin n_bad++; $display("FAIL dp_valid_count: got %0d want %0d", nval, ROWS * COLS); end
    n_cmp++; if (lag_bad != 0) begin n_bad++; $display("FAIL dp_valid_lag: got %0d errors want 0", lag_bad); end
    n_cmp++; if (zero_bad != 0) begin n_bad++; $display("FAIL dp_zero_idle: got %0d errors want 0", zero_bad); end
  endtask

  task automatic test_round_robin();
    bit ok, vsf; logic [3:0] g, eg; int w, len, nvs, nhs, runs, bad; logic [2:0] dch; logic ba;
    rstn = 1'b0; @(negedge clk); @(negedge clk); rstn = 1'b1; @(negedge clk);
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
`ifdef POOL_SCHED_PRIO_EN
      eg = 4'b0001;
`else
      eg = 4'b0001 << (f % 4);
`endif
      watch_frame(ok, g, w, len, nvs, nhs, runs, bad, dch, vsf, ba);
      n_cmp++; if (g !== eg || ok !== 1'b1) begin n_bad++; $display("FAIL rr_gnt%0d: got %b done %0d want %b done 1", f, g, ok, eg); end
      n_cmp++; if (w != 1 || ba !== 1'b0) begin n_bad++; $display("FAIL rr_idle%0d: got wait %0d busy %b want 1 0", f, w, ba); end
    end
    req = 4'b0000;
  endtask

  task automatic test_req_drop();
    bit ok, vsf, done; logic [3:0] g, g2; int w, len, nvs, nhs, runs, bad, nrd; logic [2:0] dch, dch2; logic ba;
    done = 0; len = 0; nhs = 0; nrd = 0; dch = '0; w = 0;
    req = 4'b1010;
    while (o_busy !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    g = o_gnt;
    for (int i = 0; i < 60 && o_busy === 1'b1; i++) begin
      len++;
      if (o_hsync) nhs++;
      if (o_rd === 4'b0010) nrd++;
      if (nhs == 3 && o_rd != '0 && req[1]) req[1] = 1'b0;
      if (o_done === 1'b1) begin done = 1; dch = o_done_ch; break; end
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("FAIL drop_gnt: got %b want 0010", g); end
    n_cmp++; if (done !== 1'b1 || dch !== 3'd1) begin n_bad++; $display("FAIL drop_done: got done %0d ch %0d want 1 1", done, dch); end
    n_cmp++; if (nrd != ROWS * COLS || len != FLEN) begin n_bad++; $display("FAIL drop_frame: got rd %0d len %0d want %0d %0d", nrd, len, ROWS * COLS, FLEN); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL drop_idle: got busy %b want 0", o_busy); end
    watch_frame(ok, g2, w, len, nvs, nhs, runs, bad, dch2, vsf, ba);
    req = 4'b0000;
    n_cmp++; if (ok !== 1'b1 || g2 !== 4'b1000 || dch2 !== 3'd3)
      begin n_bad++; $display("FAIL drop_next: got done %0d gnt %b ch %0d want 1 1000 3", ok, g2, dch2); end
  endtask

  task automatic test_reset_midframe();
    bit ok, vsf, reached; logic [3:0] g; int w, len, nvs, nhs, runs, bad, ndone; logic [2:0] dch; logic ba;
    reached = 0; nhs = 0; ndone = 0;
    req = 4'b0001;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_hsync) nhs++;
      if (nhs == 3 && o_rd === 4'b0001) begin reached = 1; break; end
    end
    n_cmp++; if (reached !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_row3: got %0d want 1", reached); end
    #2 rstn = 1'b0; req = 4'b0000;
    #1;
    n_cmp++; if ({o_rd, o_gnt, o_vsync, o_hsync, o_valid, o_tdata, o_busy, o_done, o_done_ch} !== 17'b0)
      begin n_bad++; $display("FAIL rstmid_async_clear: got %b want all 0", {o_rd, o_gnt, o_vsync, o_hsync, o_valid, o_tdata, o_busy, o_done, o_done_ch}); end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (o_done !== 1'b0 || o_busy !== 1'b0) ndone++; end
    n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", ndone); end
    req = 4'b0010;
    watch_frame(ok, g, w, len, nvs, nhs, runs, bad, dch, vsf, ba);
    req = 4'b0000;
    n_cmp++; if (vsf !== 1'b1 || g !== 4'b0010) begin n_bad++; $display("FAIL rstmid_fresh_start: got vsync %0d gnt %b want 1 0010", vsf, g); end
    n_cmp++; if (ok !== 1'b1 || len != FLEN || dch !== 3'd1)
      begin n_bad++; $display("FAIL rstmid_fresh_frame: got done %0d len %0d ch %0d want 1 %0d 1", ok, len, dch, FLEN); end
  endtask

  task automatic test_idle();
    int act;
    act = 0;
    req = 4'b0000;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_busy !== 1'b0 || o_rd !== 4'b0 || o_vsync !== 1'b0 || o_hsync !== 1'b0) act++;
    end
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", act); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_datapath();
    test_round_robin();
    test_req_drop();
    test_reset_midframe();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pool_frame_scheduler.md
Name: pool_frame_scheduler

Overview:
- Shares one mean-pooling engine between NCH feature-map channel buffers.
- Arbitrates between channel requests and grants one channel for a whole frame.
- Generates the engine's vsync/hsync/valid framing and strobes the granted channel's read FIFO. Sits between the per-channel line buffers and the pooling engine input.

Parameters:
- NCH, 4: number of requesting channels (2..8).
- WD, 1: pixel data width.
- COLS, 28: pixels per row (even, ≥2).
- ROWS, 28: rows per frame (even, ≥2, ≤255).
- HGAP, 4: idle cycles after each row (≥1).
- TAIL, 4: drain cycles after the last row, covering engine pipeline latency.

Ports:
- i_sclk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_req  in  NCH  per-channel frame request; held high until that channel's o_done.
- i_tdata  in  NCH*WD  flat channel data bus; channel k on bits [k*WD +: WD]; one-cycle read latency from o_rd.
- o_rd  out  NCH  one-hot read strobe to the granted channel FIFO.
- o_gnt  out  NCH  one-hot grant, held for the whole frame.
- o_vsync  out  1  frame-start pulse to the engine.
- o_hsync  out  1  row-start pulse to the engine.
- o_valid  out  1  engine data valid.
- o_tdata  out  WD  engine data.
- o_busy  out  1  high from grant until DONE.
- o_done  out  1  one-cycle end-of-frame pulse.
- o_done_ch  out  3  index of the channel finished; valid with o_done.

Behaviour:
- Clock and reset: one clock i_sclk; reset asynchronous active-low on i_rstn.
- Reset values: all outputs 0; FSM IDLE; row/col/gap counters 0; round-robin pointer 0.
- FSM states: IDLE, VS, HS, ROW, GAP, TAIL, DONE.
- IDLE: if any i_req is set, grant the winner, register o_gnt, go to VS. Otherwise stay.
- VS, 1 cycle: o_vsync=1; row counter cleared; go to HS.
- HS, 1 cycle: o_hsync=1; go to ROW.
- ROW, COLS cycles: o_rd = o_gnt; column counter runs 0..COLS-1; on the last column, row counter increments and FSM goes to GAP.
- GAP, HGAP cycles: then HS if rows done < ROWS, else TAIL.
- TAIL, TAIL cycles: then DONE.
- DONE, 1 cycle: o_done=1; o_done_ch = granted index. o_gnt and o_busy clear on the next cycle; FSM returns to IDLE.
- Outputs: o_vsync, o_hsync, o_rd, o_busy and o_done are registered decodes of the state.
- Data path: o_valid is o_rd-any delayed 1 cycle. o_tdata is the granted channel's slice of i_tdata, registered in that same cycle; o_tdata is 0 when o_valid=0.
- Frame length from IDLE exit to the o_done cycle: 1 + ROWS*(1+COLS+HGAP) + TAIL + 1 cycles.
- Arbitration: round-robin. Search starts at pointer; pointer becomes winner+1 (mod NCH) at each grant.
- Requests are sampled only in IDLE. Deassertion of i_req mid-frame is ignored and the frame completes.
- A request present during DONE is served after a 1-cycle IDLE. No back-to-back grant without IDLE.
- Reset mid-frame: immediate return to reset values; no o_done is generated.
- The engine needs contiguous rows, so o_rd is never stalled inside ROW.

Optional Feature:
- POOL_SCHED_PRIO_EN defined: fixed priority, lowest channel index wins; the pointer is unused and held at 0.
- POOL_SCHED_PRIO_EN undefined: round-robin arbitration as specified above.

Test Plan:
Bench configuration for all scenarios: NCH=4, COLS=4, ROWS=4, HGAP=2, TAIL=4.
- Single request: i_req=0001 → o_gnt=0001; one o_vsync; 4 o_hsync pulses each followed by 4 o_rd[0] cycles; o_done with o_done_ch=0 exactly 34 cycles after leaving IDLE.
- Data path: channel 2 feeds 1,0,1,1 per row → o_valid lags o_rd by 1 cycle and o_tdata reproduces the sequence; o_tdata=0 whenever o_valid=0.
- Round-robin: i_req=1111 held → grants in order 0001, 0010, 0100, 1000, 0001, each separated by DONE+IDLE. With POOL_SCHED_PRIO_EN defined → 0001 repeats.
- Request drop: i_req[1] falls during row 2 → frame still completes; o_done_ch=1; next grant goes to another requester or the FSM idles.
- Reset mid-frame: i_rstn low during ROW of row 3 → all outputs 0 asynchronously; no o_done; a fresh request afterwards starts with o_vsync.
- Idle: i_req=0 for 100 cycles → o_busy, o_rd, o_vsync and o_hsync remain 0.
